// File: rtl/multiplicador_real.sv
// multiplicador_real: sequential 8x8 shift-and-add multiplier; define MULT_ACC_RESTO_EN to add parcela to the product
module multiplicador_real #(
  parameter int N_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     multiplicando,
  input  logic [N_BITS-1:0]     multiplicador,
  input  logic [N_BITS-1:0]     parcela,
  output logic [2*N_BITS-1:0]   produto,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  zero
);
  localparam int W  = 2 * N_BITS;
  localparam int CW = $clog2(N_BITS);
  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
  state_t            state_q, state_d;
  logic [W-1:0]      mcand_q, mcand_d, acc_q, acc_d, produto_q, produto_d, acc_add, acc_init;
  logic [N_BITS-1:0] mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, zero_q, zero_d, last;
`ifdef MULT_ACC_RESTO_EN
  assign acc_init = {{N_BITS{1'b0}}, parcela};
`else
  logic unused_parcela;
  assign unused_parcela = ^parcela;
  assign acc_init = '0;
`endif
  assign produto  = produto_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  // next state: latch operands in IDLE, one shift-and-add step per CALC cycle, publish result on the last step
  always_comb begin
    acc_add   = acc_q + (mplier_q[0] ? mcand_q : '0);
    last      = state_q == CALC && cnt_q == CW'(N_BITS - 1);
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    produto_d = produto_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    if (state_q == IDLE && start) begin
      mcand_d  = {{N_BITS{1'b0}}, multiplicando};
      mplier_d = multiplicador;
      acc_d    = acc_init;
      cnt_d    = '0;
      state_d  = CALC;
    end else if (state_q == CALC) begin
      acc_d    = acc_add;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        state_d   = FIM;
        produto_d = acc_add;
        ovf_d     = |acc_add[W-1:N_BITS];
        zero_d    = acc_add == '0;
      end
    end else if (state_q == FIM) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_q == FIM;
  end
  // state and registered outputs, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      produto_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      produto_q <= produto_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end
endmodule

// File: tb/tb_multiplicador_real.sv
// tb_multiplicador_real: directed vector bench for multiplicador_real (honours MULT_ACC_RESTO_EN)
module tb_multiplicador_real;
`ifdef MULT_ACC_RESTO_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicando = '0, multiplicador = '0, parcela = '0;
  logic [15:0] produto;
  logic        busy, done, overflow, zero;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [7:0]  a, b, p;
    logic [15:0] e_plain, e_acc;
  } vec_t;
  vec_t tab[9];

  multiplicador_real #(.N_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicando(multiplicando), .multiplicador(multiplicador), .parcela(parcela),
    .produto(produto), .busy(busy), .done(done), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    for (int i = 1; i <= 25 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    if (lat == 0) chk({nm, " done timeout"}, 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, b, p, input logic [15:0] exp);
    int lat, bcnt, dcnt;
    @(negedge clk);
    multiplicando = a; multiplicador = b; parcela = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; dcnt = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = i;
      end
    end
    chk({nm, " latency"}, lat, 9);
    chk({nm, " done pulses"}, dcnt, 1);
    chk({nm, " busy cycles"}, bcnt, 9);
    chk({nm, " produto"}, produto, exp);
    chk({nm, " overflow"}, overflow, exp[15:8] != 0);
    chk({nm, " zero"}, zero, exp == 0);
  endtask

  initial begin
    int lat;
    tab[0] = '{8'd13,  8'd11,  8'd0,   16'd143,   16'd143};
    tab[1] = '{8'd255, 8'd255, 8'd255, 16'hFE01,  16'hFF00};
    tab[2] = '{8'd7,   8'd3,   8'd5,   16'd21,    16'd26};
    tab[3] = '{8'd0,   8'd200, 8'd0,   16'd0,     16'd0};
    tab[4] = '{8'd0,   8'd200, 8'd9,   16'd0,     16'd9};
    tab[5] = '{8'd1,   8'd1,   8'd0,   16'd1,     16'd1};
    tab[6] = '{8'd255, 8'd1,   8'd0,   16'd255,   16'd255};
    tab[7] = '{8'd16,  8'd16,  8'd0,   16'd256,   16'd256};
    tab[8] = '{8'd128, 8'd2,   8'd255, 16'd256,   16'd511};
    repeat (2) @(posedge clk);
    #1;
    chk("reset produto", produto, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset overflow", overflow, 0);
    chk("reset zero", zero, 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tab[i].a, tab[i].b, tab[i].p, ACC ? tab[i].e_acc : tab[i].e_plain);
    // start held high through CALC with changing operands
    @(negedge clk);
    multiplicando = 8'd13; multiplicador = 8'd11; parcela = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    multiplicando = 8'd5; multiplicador = 8'd5;
    wait_done("held", lat);
    chk("held latency", lat, 9);
    chk("held first produto", produto, 143);
    @(posedge clk); #1;
    chk("held reaccept busy", busy, 1);
    chk("held produto kept", produto, 143);
    @(negedge clk) start = 1'b0;
    wait_done("held2", lat);
    chk("held second produto", produto, 25);
    // async reset mid-operation
    @(negedge clk);
    multiplicando = 8'd200; multiplicador = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst produto", produto, 0);
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst overflow", overflow, 0);
    chk("async rst zero", zero, 0);
    @(negedge clk) rst = 1'b1;
    run_op("after rst 2*3", 8'd2, 8'd3, 8'd0, 16'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
